vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the system clock: an internal pixel tick at clk/2, horizontal and vertical counters, active-low hsync/vsync, and the `px_en` active-video strobe that the grid-to-pixel stage consumes. It also registers the 8-bit pixel colour coming back from that stage, blanks it outside active video, and delays sync by a matching amount so sync and colour reach the DAC pins aligned. It sits between the system clock/reset and the VGA connector, wrapped around the grid-to-pixel renderer.

---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (640x480 @ 60 Hz by default) from a 2x system clock.
//
// Ports
//   clk        system clock, twice the pixel rate
//   reset      asynchronous, active-low reset
//   pixel_rgb  colour from the renderer; sampled on px_tick-rising edges, the colour
//              for the pixel whose px_en was shown in tick k must be present at the
//              edge that starts tick k+DATA_LAT
//   px_tick    high for one clk out of every two; new pixel-rate values appear with it
//   px_en      active-video strobe aligned with h_count/v_count
//   h_count    current column, 0..H_TOTAL-1
//   v_count    current line, 0..V_TOTAL-1
//   frame_start one-clk pulse when the counters wrap to (0,0)
//   hsync      active-low line sync, delayed DATA_LAT ticks
//   vsync      active-low frame sync, delayed DATA_LAT ticks
//   vga_rgb    blanked, registered colour aligned with hsync/vsync
//
// DATA_LAT must lie in 1..4.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_rgb,
  output logic       px_tick,
  output logic       px_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       px_tick_r;
  logic       started_r;
  logic [9:0] h_count_r;
  logic [9:0] v_count_r;
  logic       px_en_r;
  logic       frame_start_r;
  logic       hsync_raw_r;
  logic       vsync_raw_r;
  logic [7:0] vga_rgb_r;
  // Each stage holds {hsync, vsync, blank}.
  logic [2:0] dline_r [DATA_LAT];

  logic       adv_s;
  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       wrap_s;
  logic       px_en_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;
  // Blank flag one stage short of the output, so the registered colour lands with sync.
  logic       blank_tap_s [DATA_LAT];

  // Pixel-rate state moves on the edge that raises px_tick, so new values show with it.
  assign adv_s = ~px_tick_r;

  // Pixel tick toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_tick_r <= 1'b0;
    end else begin
      px_tick_r <= ~px_tick_r;
    end
  end

  // Next counter values and their decodes; the first tick after reset presents (0,0).
  always_comb begin
    h_next_s = h_count_r;
    v_next_s = v_count_r;
    wrap_s   = 1'b0;
    if (!started_r) begin
      h_next_s = 10'd0;
      v_next_s = 10'd0;
    end else if (h_count_r == H_LAST) begin
      h_next_s = 10'd0;
      if (v_count_r == V_LAST) begin
        v_next_s = 10'd0;
        wrap_s   = 1'b1;
      end else begin
        v_next_s = v_count_r + 10'd1;
      end
    end else begin
      h_next_s = h_count_r + 10'd1;
    end
    px_en_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
    hsync_next_s = ~((h_next_s >= HS_FIRST) && (h_next_s <= HS_LAST));
    vsync_next_s = ~((v_next_s >= VS_FIRST) && (v_next_s <= VS_LAST));
  end

  // Counters plus the registered decodes that travel with them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_r     <= 1'b0;
      h_count_r     <= 10'd0;
      v_count_r     <= 10'd0;
      px_en_r       <= 1'b0;
      hsync_raw_r   <= 1'b1;
      vsync_raw_r   <= 1'b1;
      frame_start_r <= 1'b0;
    end else if (adv_s) begin
      started_r     <= 1'b1;
      h_count_r     <= h_next_s;
      v_count_r     <= v_next_s;
      px_en_r       <= px_en_next_s;
      hsync_raw_r   <= hsync_next_s;
      vsync_raw_r   <= vsync_next_s;
      frame_start_r <= wrap_s;
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  // Blank tap feeding the colour register: raw decode for a one-tick latency.
  always_comb begin
    blank_tap_s[0] = ~px_en_r;
    for (int i = 1; i < DATA_LAT; i++) begin
      blank_tap_s[i] = dline_r[i-1][0];
    end
  end

  // Sync/blank delay line, filled with idle sync and blanked video on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DATA_LAT; i++) begin
        dline_r[i] <= 3'b111;
      end
    end else if (adv_s) begin
      dline_r[0] <= {hsync_raw_r, vsync_raw_r, ~px_en_r};
      for (int i = 1; i < DATA_LAT; i++) begin
        dline_r[i] <= dline_r[i-1];
      end
    end
  end

  // Output colour register, forced to black outside delayed active video.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_rgb_r <= 8'h00;
    end else if (adv_s) begin
      vga_rgb_r <= blank_tap_s[DATA_LAT-1] ? 8'h00 : pixel_rgb;
    end
  end

  assign px_tick     = px_tick_r;
  assign px_en       = px_en_r;
  assign h_count     = h_count_r;
  assign v_count     = v_count_r;
  assign frame_start = frame_start_r;
  assign hsync       = dline_r[DATA_LAT-1][2];
  assign vsync       = dline_r[DATA_LAT-1][1];
  assign vga_rgb     = vga_rgb_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster so several frames fit in a short run.
// Three instances (DATA_LAT 2, 1, 4) share clock, reset and pixel input. Expected
// outputs per pixel tick are derived from the tick index with plain arithmetic,
// queued when the stimulus issues a pixel, and popped by an independent monitor.
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NI = 3;
  localparam int N1 = 2 * FT + 5 * HT + 11;
  localparam int N2 = 2 * FT + 20;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       en;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixel_rgb;
  logic       px_tick_w [NI];
  logic       px_en_w   [NI];
  logic       fs_w      [NI];
  logic       hs_w      [NI];
  logic       vs_w      [NI];
  logic [9:0] h_w       [NI];
  logic [9:0] v_w       [NI];
  logic [7:0] rgb_w     [NI];

  exp_t [NI-1:0] sb_q [$];
  exp_t [NI-1:0] cur;
  exp_t [NI-1:0] last_v;

  int   n_checks;
  int   n_errors;
  int   nt;
  logic run;
  logic tick_exp;
  logic have_last;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .DATA_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .pixel_rgb(pixel_rgb),
      .px_tick(px_tick_w[g]),
      .px_en(px_en_w[g]),
      .h_count(h_w[g]),
      .v_count(v_w[g]),
      .frame_start(fs_w[g]),
      .hsync(hs_w[g]),
      .vsync(vs_w[g]),
      .vga_rgb(rgb_w[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Expected outputs during pixel tick t; pix is the colour driven during tick t-1.
  function automatic exp_t model(input int t, input int lat, input logic [7:0] pix);
    exp_t e;
    int   idx, hh, vv;
    e.h  = 10'(t % HT);
    e.v  = 10'((t / HT) % VT);
    e.en = ((t % HT) < HA) && (((t / HT) % VT) < VA);
    e.fs = (t > 0) && ((t % FT) == 0);
    idx  = t - lat;
    if (idx < 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 8'h00;
    end else begin
      hh    = idx % HT;
      vv    = (idx / HT) % VT;
      e.hs  = !((hh >= HA + HF) && (hh < HA + HF + HS));
      e.vs  = !((vv >= VA + VF) && (vv < VA + VF + VS));
      e.rgb = ((hh < HA) && (vv < VA)) ? pix : 8'h00;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s lat=%0d t=%0t: got %0h, expected %0h", nm, lat_of(g), $time,
               act, expv);
    end
  endtask

  task automatic chk_reset();
    for (int g = 0; g < NI; g++) begin
      chk("rst_px_tick", g, 32'(px_tick_w[g]), 32'd0);
      chk("rst_h_count", g, 32'(h_w[g]), 32'd0);
      chk("rst_v_count", g, 32'(v_w[g]), 32'd0);
      chk("rst_px_en", g, 32'(px_en_w[g]), 32'd0);
      chk("rst_frame_start", g, 32'(fs_w[g]), 32'd0);
      chk("rst_hsync", g, 32'(hs_w[g]), 32'd1);
      chk("rst_vsync", g, 32'(vs_w[g]), 32'd1);
      chk("rst_vga_rgb", g, 32'(rgb_w[g]), 32'd0);
    end
  endtask

  task automatic push_exp(input logic [7:0] pix);
    exp_t [NI-1:0] vec;
    for (int g = 0; g < NI; g++) begin
      vec[g] = model(nt, lat_of(g), pix);
    end
    sb_q.push_back(vec);
    nt++;
  endtask

  // Release on a falling edge; tick 0 then starts on the next rising edge.
  task automatic start_run();
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    nt        = 0;
    tick_exp  = 1'b1;
    have_last = 1'b0;
    push_exp(8'h00);
    @(posedge clk);
    run = 1'b1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < 4 * n + 100 && nt < n; i++) @(posedge clk);
    n_checks++;
    if (nt < n) begin
      n_errors++;
      $display("FAIL tick_timeout: reached %0d ticks, expected %0d", nt, n);
    end
  endtask

  // Stimulus: a new pixel colour each tick, with the expectation for the next tick queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (run && px_tick_w[0]) begin
        pixel_rgb = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
        push_exp(pixel_rgb);
      end
    end
  end

  // Monitor: pops one expectation per tick, checks that nothing moves in the off cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        for (int g = 0; g < NI; g++) begin
          chk("px_tick", g, 32'(px_tick_w[g]), 32'(tick_exp));
        end
        if (tick_exp) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got no queued expectation, expected one");
          end else begin
            cur = sb_q.pop_front();
            for (int g = 0; g < NI; g++) begin
              chk("h_count", g, 32'(h_w[g]), 32'(cur[g].h));
              chk("v_count", g, 32'(v_w[g]), 32'(cur[g].v));
              chk("px_en", g, 32'(px_en_w[g]), 32'(cur[g].en));
              chk("frame_start", g, 32'(fs_w[g]), 32'(cur[g].fs));
              chk("hsync", g, 32'(hs_w[g]), 32'(cur[g].hs));
              chk("vsync", g, 32'(vs_w[g]), 32'(cur[g].vs));
              chk("vga_rgb", g, 32'(rgb_w[g]), 32'(cur[g].rgb));
            end
            last_v    = cur;
            have_last = 1'b1;
          end
        end else if (have_last) begin
          for (int g = 0; g < NI; g++) begin
            chk("hold_h_count", g, 32'(h_w[g]), 32'(last_v[g].h));
            chk("hold_v_count", g, 32'(v_w[g]), 32'(last_v[g].v));
            chk("hold_px_en", g, 32'(px_en_w[g]), 32'(last_v[g].en));
            chk("hold_frame_start", g, 32'(fs_w[g]), 32'd0);
            chk("hold_hsync", g, 32'(hs_w[g]), 32'(last_v[g].hs));
            chk("hold_vsync", g, 32'(vs_w[g]), 32'(last_v[g].vs));
            chk("hold_vga_rgb", g, 32'(rgb_w[g]), 32'(last_v[g].rgb));
          end
        end
        tick_exp = ~tick_exp;
      end
    end
  end

  // Sequence: reset hold, two-plus frames, asynchronous mid-line reset, two-plus frames.
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    run       = 1'b0;
    nt        = 0;
    tick_exp  = 1'b1;
    have_last = 1'b0;
    pixel_rgb = 8'h00;
    reset     = 1'b1;
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk_reset();
    end
    start_run();
    wait_ticks(N1);
    @(posedge clk);
    #3;
    run   = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset();
    repeat (3) @(negedge clk);
    chk_reset();
    start_run();
    wait_ticks(N2);
    @(negedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
